// File: rtl/layer_seq_if.sv
// layer_seq_if: host request/abort, config table write port and engine control of the layer sequencer.
interface layer_seq_if #(
    parameter int AW = 16,
    parameter int LW = 4
);
    logic          req, abort, busy, done, result_valid, err;
    logic          cfg_we;
    logic [7:0]    cfg_addr;
    logic [AW-1:0] cfg_wdata;
    logic          eng_rst_n, eng_start, eng_done;
    logic [LW-1:0] layer_idx;
    logic [AW-1:0] w_base, b_base;
    logic          in_sel, act_we;
    modport master (
        output req, abort, cfg_we, cfg_addr, cfg_wdata, eng_done,
        input  busy, done, result_valid, err, eng_rst_n, eng_start, layer_idx, w_base, b_base, in_sel, act_we
    );
    modport slave (
        input  req, abort, cfg_we, cfg_addr, cfg_wdata, eng_done,
        output busy, done, result_valid, err, eng_rst_n, eng_start, layer_idx, w_base, b_base, in_sel, act_we
    );
endinterface

// File: rtl/layer_seq.sv
// layer_seq: time-shares one layer engine across all layers (reset, start, wait, capture per layer).
// Optional engine-wait watchdog enabled by defining LAYER_SEQ_WDOG_EN.
module layer_seq #(
    parameter int L        = 2,
    parameter int AW       = 16,
    parameter int LW       = 4,
    parameter int WDOG_CYC = 65535
) (
    input logic        clk,
    input logic        rst_n,
    layer_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0, S_RST = 3'd1, S_START = 3'd2, S_WAIT = 3'd3,
                           S_CAPT = 3'd4, S_NEXT = 3'd5, S_FIN = 3'd6, S_ABRT = 3'd7;
    localparam int IW = (L > 1) ? $clog2(L) : 1;
    localparam logic [LW:0] N_MAX = (LW+1)'(L);
    logic [2:0]    r_state, w_next;
    logic [LW-1:0] r_layer;
    logic [LW:0]   r_n_act;
    logic [AW-1:0] r_wt [L];
    logic [AW-1:0] r_bt [L];
    logic          r_rv, w_accept, w_last, w_timeout, w_cfg;
    assign w_accept = r_state == S_IDLE && bus.req && !bus.abort;
    assign w_last   = {1'b0, r_layer} == r_n_act - 1'b1;
    assign w_cfg    = bus.cfg_we && r_state == S_IDLE;
`ifdef LAYER_SEQ_WDOG_EN
    localparam int CW = $clog2(WDOG_CYC + 1);
    logic [CW-1:0] r_wdog;
    logic          r_err;
    assign w_timeout = r_state == S_WAIT && !bus.eng_done && r_wdog == CW'(WDOG_CYC - 1);
    assign bus.err   = r_err;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= (r_state == S_WAIT) ? r_wdog + 1'b1 : '0;
            r_err  <= w_accept ? 1'b0 : (w_timeout || r_err);
        end
`else
    assign w_timeout = (WDOG_CYC < 0);
    assign bus.err   = 1'b0;
`endif
    // Abort and watchdog expiry both divert to a single engine-reset cycle before IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_RST : S_IDLE;
            S_RST:   w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  w_next = bus.eng_done ? S_CAPT : S_WAIT;
            S_CAPT:  w_next = S_NEXT;
            S_NEXT:  w_next = w_last ? S_FIN : S_RST;
            default: w_next = S_IDLE;
        endcase
        if ((r_state != S_IDLE && r_state != S_ABRT && bus.abort) || w_timeout) w_next = S_ABRT;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_layer <= '0;
            r_rv    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_layer <= (w_accept || w_next == S_ABRT) ? '0 :
                       (r_state == S_NEXT && w_next == S_RST) ? r_layer + 1'b1 : r_layer;
            r_rv    <= (w_accept || w_next == S_ABRT) ? 1'b0 : (w_next == S_FIN || r_rv);
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < L; i++) begin
                r_wt[i] <= '0;
                r_bt[i] <= '0;
            end
            r_n_act <= N_MAX;
        end else if (w_cfg) begin
            if (bus.cfg_addr[7:6] == 2'b00 && bus.cfg_addr[5:0] < 6'(L)) r_wt[bus.cfg_addr[IW-1:0]] <= bus.cfg_wdata;
            if (bus.cfg_addr[7:6] == 2'b01 && bus.cfg_addr[5:0] < 6'(L)) r_bt[bus.cfg_addr[IW-1:0]] <= bus.cfg_wdata;
            if (bus.cfg_addr == 8'h80)
                r_n_act <= (bus.cfg_wdata == '0) ? (LW+1)'(1) :
                           (bus.cfg_wdata > AW'(L)) ? N_MAX : bus.cfg_wdata[LW:0];
        end
    assign bus.busy         = r_state != S_IDLE;
    assign bus.done         = r_state == S_FIN;
    assign bus.result_valid = r_rv;
    assign bus.eng_rst_n    = !(r_state == S_RST || r_state == S_ABRT);
    assign bus.eng_start    = r_state == S_START;
    assign bus.act_we       = r_state == S_CAPT;
    assign bus.layer_idx    = r_layer;
    assign bus.in_sel       = r_layer != '0;
    assign bus.w_base       = r_wt[r_layer[IW-1:0]];
    assign bus.b_base       = r_bt[r_layer[IW-1:0]];
endmodule

// File: tb/tb_layer_seq.sv
// tb_layer_seq: randomized scoreboard bench for layer_seq with a behavioural engine and config-table model.
module tb_layer_seq;
    localparam int L = 2, AW = 16, LW = 4;
    typedef struct { int idx; int w; int b; int sel; } cap_t;
    typedef struct { int cycles; int layers; } run_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    layer_seq_if #(.AW(AW), .LW(LW)) bus();
    layer_seq #(.L(L), .AW(AW), .LW(LW), .WDOG_CYC(20)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    cap_t cap_q[$];
    run_t run_q[$];
    int n_chk = 0, n_fail = 0, lat = 10;
    int w_tab[L], b_tab[L], n_act_m;
    int eng_cnt, busy_cnt, start_cnt, ra, rd;
    bit eng_run;
    int addrs[9] = '{'h00, 'h01, 'h02, 'h40, 'h41, 'h45, 'h80, 'h81, 'hC0};
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask
    task automatic flag(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event or expired bound", nm);
    endtask
    function automatic void model_reset();
        foreach (w_tab[i]) begin
            w_tab[i] = 0;
            b_tab[i] = 0;
        end
        n_act_m = L;
    endfunction
    function automatic void model_write(input int a, input int d);
        if (a < 'h40) begin
            if (a < L) w_tab[a] = d;
        end else if (a < 'h80) begin
            if (a - 'h40 < L) b_tab[a - 'h40] = d;
        end else if (a == 'h80) n_act_m = (d == 0) ? 1 : (d > L) ? L : d;
    endfunction
    function automatic void push_cap(input int i);
        cap_t c;
        c.idx = i; c.w = w_tab[i]; c.b = b_tab[i]; c.sel = (i != 0);
        cap_q.push_back(c);
    endfunction
    // Each layer costs reset+start+capture+next plus the engine wait (at least one WAIT cycle), then one FIN cycle.
    function automatic void push_exp();
        run_t r;
        for (int i = 0; i < n_act_m; i++) push_cap(i);
        r.cycles = n_act_m * (4 + (lat < 1 ? 1 : lat)) + 1;
        r.layers = n_act_m;
        run_q.push_back(r);
    endfunction
    task automatic cfg_write(input int a, input int d, input bit upd);
        bus.cfg_we = 1'b1; bus.cfg_addr = 8'(a); bus.cfg_wdata = 16'(d);
        tick();
        bus.cfg_we = 1'b0;
        if (upd) model_write(a, d);
    endtask
    task automatic wait_idle(input string nm);
        for (int i = 0; i < 1000; i++) begin
            if (!bus.busy) return;
            tick();
        end
        flag(nm);
    endtask
    task automatic run(input int l, input bit poke);
        lat = l;
        push_exp();
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        check("busy_after_req", bus.busy, 1);
        check("eng_rst_low_k1", bus.eng_rst_n, 0);
        check("rv_cleared_on_req", bus.result_valid, 0);
        check("err_cleared_on_req", bus.err, 0);
        tick();
        check("eng_start_k2", bus.eng_start, 1);
        check("eng_rst_high_k2", bus.eng_rst_n, 1);
        if (poke) cfg_write('h00, 'hFFFF, 1'b0);
        wait_idle("run_timeout");
        check("rv_after_run", bus.result_valid, 1);
    endtask
    initial begin
        bus.eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!bus.eng_rst_n) begin
                bus.eng_done = 1'b0;
                eng_run = 1'b0;
            end else if (bus.eng_start) begin
                eng_run = 1'b1;
                eng_cnt = 0;
                bus.eng_done = (lat == 0);
            end else if (eng_run && !bus.eng_done) begin
                eng_cnt++;
                if (lat >= 0 && eng_cnt >= lat) bus.eng_done = 1'b1;
            end
        end
    end
    initial begin
        cap_t c;
        run_t r;
        busy_cnt = 0;
        start_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            else begin
                busy_cnt = 0;
                start_cnt = 0;
            end
            if (bus.eng_start) start_cnt++;
            if (bus.act_we) begin
                if (cap_q.size() == 0) flag("act_we_unexpected");
                else begin
                    c = cap_q.pop_front();
                    check("cap_layer_idx", bus.layer_idx, c.idx);
                    check("cap_w_base", bus.w_base, c.w);
                    check("cap_b_base", bus.b_base, c.b);
                    check("cap_in_sel", bus.in_sel, c.sel);
                end
            end
            if (bus.done) begin
                if (run_q.size() == 0) flag("done_unexpected");
                else begin
                    r = run_q.pop_front();
                    check("busy_cycles", busy_cnt, r.cycles);
                    check("eng_start_pulses", start_cnt, r.layers);
                    check("rv_with_done", bus.result_valid, 1);
                end
            end
        end
    end
    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
    initial begin
        bus.req = 1'b0; bus.abort = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rv", bus.result_valid, 0);
        check("rst_err", bus.err, 0);
        check("rst_eng_rst_n", bus.eng_rst_n, 1);
        check("rst_eng_start", bus.eng_start, 0);
        check("rst_act_we", bus.act_we, 0);
        check("rst_layer_idx", bus.layer_idx, 0);
        check("rst_in_sel", bus.in_sel, 0);
        check("rst_w_base", bus.w_base, 0);
        check("rst_b_base", bus.b_base, 0);
        rst_n = 1'b1;
        tick();
        cfg_write('h00, 'h0000, 1'b1);
        cfg_write('h01, 'h1D60, 1'b1);
        cfg_write('h40, 'h4000, 1'b1);
        cfg_write('h41, 'h404B, 1'b1);
        cfg_write('h80, 2, 1'b1);
        run(10, 1'b0);
        cfg_write('h80, 0, 1'b1);
        run(10, 1'b0);
        cfg_write('h80, 5, 1'b1);
        run(3, 1'b0);
        run(10, 1'b1);
        run(4, 1'b0);
        bus.req = 1'b1; bus.abort = 1'b1;
        tick();
        check("abort_blocks_req", bus.busy, 0);
        bus.req = 1'b0; bus.abort = 1'b0;
        lat = 10;
        push_cap(0);
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        for (int i = 0; i < 200 && !(bus.eng_start && bus.layer_idx == 1); i++) tick();
        check("layer1_started", bus.eng_start && bus.layer_idx == 1, 1);
        repeat (3) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_eng_rst_low", bus.eng_rst_n, 0);
        check("abort_layer_idx", bus.layer_idx, 0);
        check("abort_rv", bus.result_valid, 0);
        check("abort_no_done", bus.done, 0);
        tick();
        check("abort_idle", bus.busy, 0);
        check("abort_eng_rst_rel", bus.eng_rst_n, 1);
        check("abort_no_done2", bus.done, 0);
        lat = 0;
        push_exp();
        push_exp();
        bus.req = 1'b1;
        tick();
        for (int i = 0; i < 200 && !bus.done; i++) tick();
        check("b2b_first_done", bus.done, 1);
        tick();
        check("b2b_idle_gap", bus.busy, 0);
        check("b2b_rv_gap", bus.result_valid, 1);
        tick();
        check("b2b_restart", bus.busy, 1);
        check("b2b_eng_rst_low", bus.eng_rst_n, 0);
        bus.req = 1'b0;
        wait_idle("b2b_timeout");
        for (int it = 0; it < 6; it++) begin
            repeat (3) begin
                ra = addrs[$urandom_range(0, 8)];
                rd = (ra == 'h80) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 65535));
                cfg_write(ra, rd, 1'b1);
            end
            cfg_write('h80, $urandom_range(0, 5), 1'b1);
            run($urandom_range(0, 12), 1'b0);
        end
        lat = 10;
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #2;
        check("arst_busy", bus.busy, 0);
        check("arst_eng_rst_n", bus.eng_rst_n, 1);
        check("arst_layer_idx", bus.layer_idx, 0);
        check("arst_eng_start", bus.eng_start, 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        run(2, 1'b0);
`ifdef LAYER_SEQ_WDOG_EN
        lat = -1;
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        repeat (21) tick();
        check("wdog_not_yet", bus.err, 0);
        check("wdog_still_wait", bus.eng_rst_n, 1);
        tick();
        check("wdog_err", bus.err, 1);
        check("wdog_abort_rst", bus.eng_rst_n, 0);
        tick();
        check("wdog_idle", bus.busy, 0);
        check("wdog_err_sticky", bus.err, 1);
        run(3, 1'b0);
`endif
        repeat (5) tick();
        check("cap_q_drained", cap_q.size(), 0);
        check("run_q_drained", run_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
